eq_band_mixer: RTL and testbench

Downstream stage of the five FIR band filters in the audio equalizer. Collects one output sample from each band, scales each by a per-band gain, and sums the results with a single time-shared multiplier. The sum is saturated (or wrapped) to one 16-bit equalized sample. Its output feeds the audio output path.

---
 rtl/eq_pkg.sv | 21 ++
 rtl/eq_sat16.sv | 40 ++++
 rtl/eq_band_mixer.sv | 129 ++++++++++++
 tb/tb_eq_band_mixer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared constants and types for the equalizer band mixer.
//   N_BAND/DATA_W/GAIN_W/GAIN_FRAC : datapath geometry (gain is unsigned Q2.6)
//   PROD_W : width of one sample*gain product (signed, gain zero-extended)
//   ACC_W  : accumulator width, PROD_W + clog2(N_BAND), cannot overflow
//   mix_state_e : mixer FSM states
package eq_pkg;
  localparam int N_BAND    = 5;
  localparam int DATA_W    = 16;
  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 6;
  localparam int PROD_W    = DATA_W + GAIN_W + 1;
  localparam int ACC_W     = 28;
  localparam int IDX_W     = 3;
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'd64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2
  } mix_state_e;
endpackage

// File: rtl/eq_sat16.sv
// eq_sat16: combinational shift-and-fit of the mixer accumulator.
//   acc  in  ACC_W  : signed accumulated sum of sample*gain products
//   y    out DATA_W : acc >>> GAIN_FRAC fitted to DATA_W bits
//   clip out 1      : high when the fitted value was clamped
// Macro EQ_MIX_SAT_EN: defined -> clamp to the signed DATA_W range and flag
// clipping; undefined -> keep the low DATA_W bits (two's-complement wrap).
module eq_sat16
  import eq_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] y,
  output logic                     clip
);
  logic signed [ACC_W-1:0] shifted;

  // Arithmetic shift: negative sums round toward minus infinity.
  assign shifted = acc >>> GAIN_FRAC;

`ifdef EQ_MIX_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  always_comb begin
    y    = shifted[DATA_W-1:0];
    clip = 1'b0;
    if (shifted > SAT_MAX) begin
      y    = 16'h7fff;
      clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      y    = 16'h8000;
      clip = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_W-1:DATA_W];
  assign y    = shifted[DATA_W-1:0];
  assign clip = 1'b0;
`endif
endmodule

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: collects one sample per band, scales each by its gain with a
// single time-shared multiplier, and emits the fitted sum.
//   clk, rst_n  : clock, async active-low reset
//   band_valid  : per-band one-cycle sample strobe
//   band_data   : band b sample at [b*DATA_W +: DATA_W], signed
//   gain        : band b gain at [b*GAIN_W +: GAIN_W], unsigned Q2.6
//   y_out       : mixed sample, held between updates
//   y_valid     : one-cycle pulse when y_out updates
//   overrun     : sticky, a band delivered twice within one frame
//   clip        : pulses with y_valid when the sum was clamped
// Macro EQ_MIX_SAT_EN selects saturation (defined) or wrap (undefined).
module eq_band_mixer
  import eq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BAND-1:0]          band_valid,
  input  logic [N_BAND*DATA_W-1:0]   band_data,
  input  logic [N_BAND*GAIN_W-1:0]   gain,
  output logic [DATA_W-1:0]          y_out,
  output logic                       y_valid,
  output logic                       overrun,
  output logic                       clip
);
  mix_state_e                         state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [N_BAND-1:0]                  mask_q, mask_d;
  logic signed [ACC_W-1:0]            acc_q, acc_d;
  logic [N_BAND-1:0][DATA_W-1:0]      hold_q, hold_d;
  logic [N_BAND-1:0][DATA_W-1:0]      work_q, work_d;
  logic [N_BAND-1:0][GAIN_W-1:0]      gwork_q, gwork_d;
  logic [DATA_W-1:0]                  y_q, y_d;
  logic                               y_valid_q, y_valid_d;
  logic                               overrun_q, overrun_d;
  logic                               clip_q, clip_d;

  logic                               start;
  logic signed [PROD_W-1:0]           prod;
  logic [DATA_W-1:0]                  fit_y;
  logic                               fit_clip;

  assign start = (state_q == IDLE) && (&(mask_q | band_valid));

  // Gain is zero-extended by one bit so the multiply is fully signed.
  assign prod = $signed(work_q[idx_q]) * $signed({1'b0, gwork_q[idx_q]});

  eq_sat16 u_fit (
    .acc  (acc_q),
    .y    (fit_y),
    .clip (fit_clip)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    hold_d    = hold_q;
    work_d    = work_q;
    gwork_d   = gwork_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    clip_d    = 1'b0;
    overrun_d = overrun_q | (|(band_valid & mask_q));
    // A valid on the start edge belongs to the frame being launched.
    mask_d    = start ? '0 : (mask_q | band_valid);

    for (int b = 0; b < N_BAND; b++) begin
      if (band_valid[b]) hold_d[b] = band_data[b*DATA_W +: DATA_W];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          // hold_d already merges same-cycle arrivals into the frame.
          work_d  = hold_d;
          gwork_d = gain;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        if (idx_q == IDX_W'(N_BAND-1)) state_d = SCALE;
        else                           idx_d   = idx_q + IDX_W'(1);
      end
      SCALE: begin
        y_d       = fit_y;
        clip_d    = fit_clip;
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      acc_q     <= '0;
      hold_q    <= '0;
      work_q    <= '0;
      gwork_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      acc_q     <= acc_d;
      hold_q    <= hold_d;
      work_q    <= work_d;
      gwork_q   <= gwork_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
      clip_q    <= clip_d;
    end
  end

  assign y_out   = y_q;
  assign y_valid = y_valid_q;
  assign overrun = overrun_q;
  assign clip    = clip_q;
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: directed vectors with a queue scoreboard. Stimulus pushes
// the expected (cycle, y_out, clip) for each frame; the monitor pops on every
// y_valid and compares value and arrival cycle.
module tb_eq_band_mixer;
  logic        clk;
  logic        rst_n;
  logic [4:0]  band_valid;
  logic [79:0] band_data;
  logic [39:0] gain;
  logic [15:0] y_out;
  logic        y_valid;
  logic        overrun;
  logic        clip;

  logic signed [15:0] d [5];
  logic [7:0]         g [5];

  for (genvar b = 0; b < 5; b++) begin : g_pack
    assign band_data[b*16 +: 16] = d[b];
    assign gain[b*8 +: 8]        = g[b];
  end

  eq_band_mixer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .band_valid (band_valid),
    .band_data  (band_data),
    .gain       (gain),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .overrun    (overrun),
    .clip       (clip)
  );

  typedef struct {
    int          cyc;
    logic [15:0] y;
    logic        clip;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: cyc=%0d, required finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every y_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (y_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y_valid: cyc=%0d y_out=%0h, required no pulse", cyc, y_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y_cycle", 16'(cyc), 16'(e.cyc));
        chk("y_out", y_out, e.y);
        chk("clip", {15'd0, clip}, {15'd0, e.clip});
      end
    end
  end

  task automatic push_exp(input int c, input logic [15:0] y, input logic cl);
    exp_t e;
    e.cyc = c; e.y = y; e.clip = cl;
    q.push_back(e);
  endtask

  // Strobe valids for one edge; e0 is the cycle count of that edge.
  task automatic send(input logic [4:0] v, output int e0);
    band_valid = v;
    @(posedge clk);
    #1;
    e0 = cyc;
    band_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic signed [15:0] dv, input logic [7:0] gv);
    for (int b = 0; b < 5; b++) begin
      d[b] = dv;
      g[b] = gv;
    end
  endtask

  initial begin
    int e0, e1;
    logic [15:0] full_y;
    logic        full_clip;
    rst_n = 1'b0;
    band_valid = '0;
    set_all(16'sd0, 8'd0);
    idle(3);
    @(negedge clk);
    chk("rst_y_out", y_out, 16'd0);
    chk("rst_y_valid", {15'd0, y_valid}, 16'd0);
    chk("rst_overrun", {15'd0, overrun}, 16'd0);
    chk("rst_clip", {15'd0, clip}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Unity gains, same-cycle arrival.
    set_all(16'sd0, 8'd64);
    d[0] = 16'sd1000; d[1] = 16'sd2000; d[2] = 16'sd3000; d[3] = -16'sd500; d[4] = 16'sd0;
    send(5'b11111, e0);
    push_exp(e0 + 6, 16'd5500, 1'b0);
    idle(9);

    // Staggered arrival: 100*(64+128+32+0+64)/64 = 450.
    set_all(16'sd100, 8'd64);
    g[1] = 8'd128; g[2] = 8'd32; g[3] = 8'd0;
    send(5'b10000, e0);
    send(5'b00001, e0);
    send(5'b01000, e0);
    send(5'b00010, e0);
    send(5'b00100, e0);
    push_exp(e0 + 6, 16'd450, 1'b0);
    idle(9);

    // Next frame completes while busy: starts on the first IDLE edge (E7).
    set_all(16'sd10, 8'd64);
    send(5'b11111, e0);
    idle(1);
    set_all(16'sd20, 8'd64);
    send(5'b11111, e1);
    push_exp(e0 + 6, 16'd50, 1'b0);
    push_exp(e0 + 13, 16'd100, 1'b0);
    idle(16);

    // Full-scale sum: 5*32767*255 >>> 6 = 652780.
`ifdef EQ_MIX_SAT_EN
    full_y = 16'h7fff; full_clip = 1'b1;
`else
    full_y = 16'hf5ec; full_clip = 1'b0;
`endif
    set_all(16'sd32767, 8'd255);
    send(5'b11111, e0);
    push_exp(e0 + 6, full_y, full_clip);
    idle(9);

    // Negative rounding: -1*1 >>> 6 = -1.
    set_all(16'sd1234, 8'd0);
    d[0] = -16'sd1; g[0] = 8'd1;
    send(5'b11111, e0);
    push_exp(e0 + 6, 16'hffff, 1'b0);
    idle(9);

    // Overrun: band 2 delivers twice, latest sample wins.
    chk("overrun_before", {15'd0, overrun}, 16'd0);
    set_all(16'sd0, 8'd64);
    d[2] = 16'sd7;
    send(5'b00100, e0);
    d[2] = 16'sd9;
    send(5'b00100, e0);
    chk("overrun_set", {15'd0, overrun}, 16'd1);
    send(5'b11011, e0);
    push_exp(e0 + 6, 16'd9, 1'b0);
    idle(9);
    chk("overrun_sticky", {15'd0, overrun}, 16'd1);

    // Reset on E3 of a frame, with a next-frame band pending.
    set_all(16'sd1000, 8'd64);
    send(5'b11111, e0);
    send(5'b00001, e1);
    idle(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_y_out", y_out, 16'd0);
    chk("midrst_y_valid", {15'd0, y_valid}, 16'd0);
    chk("midrst_overrun", {15'd0, overrun}, 16'd0);
    chk("midrst_clip", {15'd0, clip}, 16'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    // Bands 1..4 alone must not start: the pending band 0 was discarded.
    send(5'b11110, e0);
    idle(12);
    chk("midrst_no_y", {15'd0, y_out}, 16'd0);
    send(5'b00001, e0);
    push_exp(e0 + 6, 16'd5000, 1'b0);

    for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected outputs never arrived, required 0", q.size());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
